// File: rtl/dmem_bus_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : dmem_bus_ctrl_if
// Brief    : Request/acknowledge data-memory bus between dmem_bus_ctrl
//            (master) and a variable-latency data memory (slave).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface dmem_bus_ctrl_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_ack
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module   : dmem_bus_ctrl
// Brief    : M-stage data-memory controller. Turns the core's single-cycle
//            load/store into a req/ack bus transaction, stalls the pipeline
//            while it is outstanding and flags misaligned word accesses.
//            Optional macro DMEM_TIMEOUT_EN adds a BUSY-cycle watchdog that
//            aborts the access after TIMEOUT_CYCLES cycles without ack.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        memreadM,
  input  wire logic        memwriteM,
  input  wire logic [31:0] aluoutM,
  input  wire logic [31:0] writedataM,
  output logic [31:0]      readdataM,
  output logic             stallM,
  output logic             adelM,
  output logic             adesM,
  dmem_bus_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Elaboration-time sanity check of the configuration
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535 || $bits(ERR_RDATA) != 32) begin : g_bad_param
    $error("dmem_bus_ctrl: TIMEOUT_CYCLES must be in 1..65535");
  end

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] readdata_q, readdata_d;

  logic access;
  logic aligned;

`ifdef DMEM_TIMEOUT_EN
  // Counter value seen in the last BUSY cycle before the access is aborted
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  assign access  = memreadM | memwriteM;
  assign aligned = (aluoutM[1:0] == 2'b00);

  // Combinational core-side status: stall and address-error flags
  always_comb begin
    stallM = 1'b0;
    adelM  = 1'b0;
    adesM  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned)        stallM = 1'b1;
          else if (memwriteM) adesM  = 1'b1;   // load+store together counts as a store
          else                adelM  = 1'b1;
        end
      end
      BUSY:    stallM = 1'b1;
      default: ;
    endcase
  end

  // Next-state and next-output computation for the bus FSM
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    readdata_d  = readdata_q;
`ifdef DMEM_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (access && aligned) begin
          bus_req_d   = 1'b1;
          bus_we_d    = memwriteM;
          bus_addr_d  = {aluoutM[31:2], 2'b00};
          bus_wdata_d = writedataM;
          state_d     = BUSY;
`ifdef DMEM_TIMEOUT_EN
          cnt_d       = 16'd0;
`endif
        end
      end
      BUSY: begin
        // An ack always beats a simultaneous timeout expiry
        if (bus.bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) readdata_d = bus.bus_rdata;
          state_d   = DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          bus_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (!bus_we_q) readdata_d = ERR_RDATA;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      // DONE never accepts a new access so the held instruction is not reissued
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      readdata_q  <= 32'd0;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= 16'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      readdata_q  <= readdata_d;
`ifdef DMEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
      bus_err_q   <= bus_err_d;
`endif
    end
  end

  assign bus.bus_req   = bus_req_q;
  assign bus.bus_we    = bus_we_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign readdataM     = readdata_q;
`ifdef DMEM_TIMEOUT_EN
  assign bus.bus_err   = bus_err_q;
`else
  assign bus.bus_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_bus_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_bus_ctrl
// Brief    : Self-checking bench for dmem_bus_ctrl. A memory responder acks
//            after a programmable number of wait cycles; a bus monitor
//            checks each transaction against a queue of expected results.
//            Honours DMEM_TIMEOUT_EN the same way as the design.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_bus_ctrl;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          ncyc;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memreadM = 1'b0;
  logic        memwriteM = 1'b0;
  logic [31:0] aluoutM = 32'd0;
  logic [31:0] writedataM = 32'd0;
  logic [31:0] readdataM;
  logic        stallM;
  logic        adelM;
  logic        adesM;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_wait = 0;          // -1: never ack
  logic [31:0] mem_rdata = 32'd0;
  logic        stray_ack = 1'b0;
  logic        mon_en = 1'b1;
  logic [31:0] last_rdata = 32'd0;
  txn_t        exp_q[$];
  int          rise_cyc[$];

  dmem_bus_ctrl_if bus ();

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA     (ERR)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .memreadM  (memreadM),
    .memwriteM (memwriteM),
    .aluoutM   (aluoutM),
    .writedataM(writedataM),
    .readdataM (readdataM),
    .stallM    (stallM),
    .adelM     (adelM),
    .adesM     (adesM),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Memory responder: drives ack/rdata on the falling edge for the next rising edge
  initial begin
    int busy_cnt;
    busy_cnt = 0;
    bus.bus_ack   = 1'b0;
    bus.bus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (stray_ack) begin
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = 32'h5A5A_5A5A;
      end else if (bus.bus_req && mem_wait >= 0 && busy_cnt == mem_wait) begin
        bus.bus_ack   = 1'b1;
        bus.bus_rdata = mem_rdata;
      end else begin
        bus.bus_ack   = 1'b0;
        bus.bus_rdata = 32'h0BAD_0BAD;
      end
      busy_cnt = bus.bus_req ? busy_cnt + 1 : 0;
    end
  end

  // Bus monitor: request fields on rise, stability while high, results on fall
  initial begin
    logic req_prev;
    txn_t cur;
    int   req_cnt;
    req_prev = 1'b0;
    req_cnt  = 0;
    forever begin
      sample();
      if (mon_en) begin
        if (bus.bus_req && !req_prev) begin
          rise_cyc.push_back(cyc);
          check_eq("req_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            cur = exp_q[0];
            req_cnt = 1;
            check_eq("bus_we", 32'(bus.bus_we), 32'(cur.we));
            check_eq("bus_addr", bus.bus_addr, cur.addr);
            if (cur.we) check_eq("bus_wdata", bus.bus_wdata, cur.wdata);
          end
        end else if (bus.bus_req && req_prev) begin
          req_cnt++;
          check_eq("hold_we", 32'(bus.bus_we), 32'(cur.we));
          check_eq("hold_addr", bus.bus_addr, cur.addr);
          if (cur.we) check_eq("hold_wdata", bus.bus_wdata, cur.wdata);
        end else if (!bus.bus_req && req_prev && exp_q.size() != 0) begin
          cur = exp_q.pop_front();
          check_eq("readdataM", readdataM, cur.rdata);
          check_eq("bus_err", 32'(bus.bus_err), 32'(cur.err));
          check_eq("req_cycles", 32'(req_cnt), 32'(cur.ncyc));
        end
      end
      req_prev = bus.bus_req;
    end
  end

  // Count stall cycles until the DONE cycle (stallM low); bounded
  task automatic wait_done(output int stalls);
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      sample();
      if (!stallM) break;
      stalls++;
      tick();
    end
  endtask

  function automatic txn_t make_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                    input int wait_c, input logic [31:0] rdata, input logic err);
    txn_t t;
    t.we    = we;
    t.addr  = addr;
    t.wdata = wdata;
    t.err   = err;
    t.ncyc  = err ? TO : wait_c + 1;
    if (we) t.rdata = last_rdata;
    else    t.rdata = err ? ERR : rdata;
    return t;
  endfunction

  // One aligned access; called right after a rising edge, returns after the next one
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input int wait_c, input logic [31:0] rdata, input int exp_stall,
                           input logic err, input string tag);
    txn_t t;
    int   stalls;
    t = make_txn(we, addr, wdata, wait_c, rdata, err);
    last_rdata = t.rdata;
    exp_q.push_back(t);
    mem_wait   = wait_c;
    mem_rdata  = rdata;
    memreadM   = ~we;
    memwriteM  = we;
    aluoutM    = addr;
    writedataM = wdata;
    wait_done(stalls);
    check_eq({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    tick();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
  endtask

  initial begin
    int   stalls;
    txn_t t;

    // Reset state
    repeat (3) tick();
    sample();
    check_eq("rst_bus_req", 32'(bus.bus_req), 32'd0);
    check_eq("rst_bus_we", 32'(bus.bus_we), 32'd0);
    check_eq("rst_bus_addr", bus.bus_addr, 32'd0);
    check_eq("rst_bus_wdata", bus.bus_wdata, 32'd0);
    check_eq("rst_readdata", readdataM, 32'd0);
    check_eq("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check_eq("rst_stall", 32'(stallM), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Zero-wait load, waited store, load at the top word address
    do_access(1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 2, 1'b0, "ld0");
    do_access(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 3, 32'h0, 5, 1'b0, "st0");
    do_access(1'b0, 32'hFFFF_FFFC, 32'h0, 1, 32'h8765_4321, 3, 1'b0, "ld1");

    // Misaligned load, store, and load+store (treated as a store)
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0002;
    sample();
    check_eq("mis_ld_adel", 32'(adelM), 32'd1);
    check_eq("mis_ld_ades", 32'(adesM), 32'd0);
    check_eq("mis_ld_stall", 32'(stallM), 32'd0);
    tick();
    memreadM  = 1'b0;
    memwriteM = 1'b1;
    aluoutM   = 32'h0000_0003;
    sample();
    check_eq("mis_ld_req", 32'(bus.bus_req), 32'd0);
    check_eq("mis_ld_rdata", readdataM, last_rdata);
    check_eq("mis_st_ades", 32'(adesM), 32'd1);
    check_eq("mis_st_adel", 32'(adelM), 32'd0);
    check_eq("mis_st_stall", 32'(stallM), 32'd0);
    tick();
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0001;
    sample();
    check_eq("mis_st_req", 32'(bus.bus_req), 32'd0);
    check_eq("mis_both_ades", 32'(adesM), 32'd1);
    check_eq("mis_both_adel", 32'(adelM), 32'd0);
    tick();
    memreadM  = 1'b0;
    memwriteM = 1'b0;
    sample();
    check_eq("mis_both_req", 32'(bus.bus_req), 32'd0);
    tick();

    // Back-to-back load then store held on the M port
    rise_cyc.delete();
    t = make_txn(1'b0, 32'h0000_0020, 32'h0, 0, 32'hA5A5_0001, 1'b0);
    last_rdata = t.rdata;
    exp_q.push_back(t);
    t = make_txn(1'b1, 32'h0000_0024, 32'h0BB0_0BB0, 0, 32'h0, 1'b0);
    exp_q.push_back(t);
    mem_wait  = 0;
    mem_rdata = 32'hA5A5_0001;
    memreadM  = 1'b1;
    aluoutM   = 32'h0000_0020;
    wait_done(stalls);
    check_eq("b2b_ld_stall", 32'(stalls), 32'd2);
    tick();
    memreadM   = 1'b0;
    memwriteM  = 1'b1;
    aluoutM    = 32'h0000_0024;
    writedataM = 32'h0BB0_0BB0;
    wait_done(stalls);
    check_eq("b2b_st_stall", 32'(stalls), 32'd2);
    tick();
    memwriteM = 1'b0;
    sample();
    check_eq("b2b_req_count", 32'(rise_cyc.size()), 32'd2);
    if (rise_cyc.size() == 2)
      check_eq("b2b_spacing", 32'(rise_cyc[1] - rise_cyc[0]), 32'd3);
    tick();

    // Reset in the second BUSY cycle, then a stray ack
    mon_en   = 1'b0;
    mem_wait = -1;
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0040;
    tick();
    tick();
    sample();
    check_eq("rb_busy_req", 32'(bus.bus_req), 32'd1);
    check_eq("rb_busy_stall", 32'(stallM), 32'd1);
    rst = 1'b1;
    tick();
    rst       = 1'b0;
    memreadM  = 1'b0;
    stray_ack = 1'b1;
    sample();
    check_eq("rb_req", 32'(bus.bus_req), 32'd0);
    check_eq("rb_rdata", readdataM, 32'd0);
    check_eq("rb_stall", 32'(stallM), 32'd0);
    tick();
    stray_ack = 1'b0;
    sample();
    check_eq("rb_stray_req", 32'(bus.bus_req), 32'd0);
    check_eq("rb_stray_rdata", readdataM, 32'd0);
    check_eq("rb_stray_stall", 32'(stallM), 32'd0);
    exp_q.delete();
    last_rdata = 32'd0;
    mon_en     = 1'b1;
    tick();

`ifdef DMEM_TIMEOUT_EN
    // Ack never arrives: abort after TO BUSY cycles
    do_access(1'b0, 32'h0000_0080, 32'h0, -1, 32'h1111_1111, 1 + TO, 1'b1, "to_ld");
    sample();
    check_eq("to_err_pulse", 32'(bus.bus_err), 32'd0);
    check_eq("to_rdata_hold", readdataM, ERR);
    tick();
`else
    // Ack never arrives: the stall is held indefinitely
    mon_en   = 1'b0;
    mem_wait = -1;
    memreadM = 1'b1;
    aluoutM  = 32'h0000_0080;
    repeat (100) tick();
    sample();
    check_eq("noto_stall", 32'(stallM), 32'd1);
    check_eq("noto_req", 32'(bus.bus_req), 32'd1);
    check_eq("noto_err", 32'(bus.bus_err), 32'd0);
    tick();
    rst      = 1'b1;
    memreadM = 1'b0;
    tick();
    rst = 1'b0;
    sample();
    check_eq("noto_rst_req", 32'(bus.bus_req), 32'd0);
    mon_en = 1'b1;
    tick();
`endif

    // Scoreboard must be drained
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_bus_ctrl.md
# dmem_bus_ctrl

Memory-stage data-memory controller that sits directly downstream of the `mips` core's M-stage data port. It converts the core's single-cycle load/store signals (`memwriteM`, `aluoutM`, `writedataM`, `readdataM`) into a request/acknowledge bus transaction toward a variable-latency data memory. While the transaction is outstanding it freezes the pipeline with `stallM`. It also flags misaligned word accesses so the address-error exception logic can act on them.

## Interface
- `TIMEOUT_CYCLES`, default 255: BUSY cycles without `bus_ack` before the access is aborted (only with `DMEM_TIMEOUT_EN`); range 1..65535.
- `ERR_RDATA`, default 32'hDEAD_BEEF: value returned on `readdataM` for an aborted load.

Ports:
- `clk`  in  1  the single clock; rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `memreadM`  in  1  M-stage load (the core's `memtoregM`).
- `memwriteM`  in  1  M-stage store.
- `aluoutM`  in  32  byte address.
- `writedataM`  in  32  store data.
- `readdataM`  out  32  load data to the W-stage register.
- `stallM`  out  1  freeze F/D/E/M while high.
- `adelM`  out  1  misaligned load (combinational).
- `adesM`  out  1  misaligned store (combinational).
- `bus_req`  out  1  transaction request (registered).
- `bus_we`  out  1  1 = write (registered).
- `bus_addr`  out  32  word-aligned address (registered).
- `bus_wdata`  out  32  write data (registered).
- `bus_rdata`  in  32  read data, valid with `bus_ack`.
- `bus_ack`  in  1  one-cycle completion strobe.
- `bus_err`  out  1  one-cycle timeout pulse (registered).

## Operation
States: IDLE, BUSY, DONE. Reset values: state IDLE, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `readdataM`=0, `bus_err`=0, timeout counter 0.
- Access = `memreadM | memwriteM`. If both are high, the access is treated as a store.
- **IDLE**, access, `aluoutM[1:0]==0`:
  - `stallM`=1 combinationally.
  - Latch address, data and `we`; set `bus_req`=1.
  - Next state BUSY.
- **IDLE**, access, `aluoutM[1:0]!=0`:
  - No bus activity, `stallM`=0, stay IDLE.
  - Raise `adelM` for a load or `adesM` for a store.
  - `readdataM` is unchanged.
- `adelM`/`adesM` are asserted only in IDLE; they are 0 in BUSY and DONE.
- **BUSY**:
  - `stallM`=1; `bus_req`, `bus_we`, `bus_addr`, `bus_wdata` held stable.
  - On `bus_ack`=1: for a load, `readdataM`<=`bus_rdata` (store leaves `readdataM` unchanged); `bus_req`<=0; next state DONE.
- **DONE**:
  - `stallM`=0; the core advances at the end of this cycle.
  - A new access in DONE is never accepted, so the same instruction is not reissued. Next state is always IDLE.
- `readdataM` holds its value until the next completed load.
- `bus_ack` outside BUSY is ignored.

## Timing
- A zero-wait `bus_ack` arrives in the first BUSY cycle. Cycle N is IDLE (stall), N+1 is BUSY with `bus_req`=1 and ack, N+2 is DONE. That is 2 stall cycles, and `readdataM` is valid in N+2.
- Each wait cycle before `bus_ack` adds one stall cycle.
- `bus_req` rises at the edge ending cycle N and falls at the edge where `bus_ack` is sampled.
- Back-to-back accesses: the second access is accepted in the IDLE cycle after DONE. Minimum spacing is 3 cycles per access.
- Reset asserted in any state: at the next edge the state is IDLE, `bus_req`=0, and the counter is cleared. A late `bus_ack` after reset is ignored.

## Configuration
- `DMEM_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT_CYCLES` without ack: `bus_req`<=0, `bus_err`<=1 for one cycle, and the next state is DONE.
  - For a load, `readdataM`<=`ERR_RDATA`.
  - An ack arriving in the same cycle as expiry wins: the access completes normally with no `bus_err`.
- `DMEM_TIMEOUT_EN` undefined: the counter is not built, BUSY waits indefinitely, and `bus_err` is tied to 0.

## Test plan
- Load at 0x0000_0010 with ack in the first BUSY cycle, `bus_rdata`=0x1234_5678 -> `stallM` high for exactly 2 cycles, `bus_we`=0, `bus_addr`=0x10, `readdataM`=0x1234_5678 in DONE.
- Store 0xCAFE_F00D to 0x0000_0100 with ack after 3 wait cycles -> `stallM` high for 5 cycles, `bus_we`=1, `bus_wdata`=0xCAFE_F00D held for all 4 `bus_req` cycles.
- Load at 0x0000_0002 -> `adelM`=1 the same cycle, `stallM`=0, `bus_req` never rises, `readdataM` unchanged. Store at 0x0000_0003 -> `adesM`=1, no bus activity.
- `rst` pulsed in the second BUSY cycle, then ack one cycle later -> state IDLE, `bus_req`=0, `readdataM`=0, the stray ack is ignored.
- With `DMEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, ack never arrives -> after 4 BUSY cycles `bus_req` drops, `bus_err` pulses for 1 cycle, `readdataM`=0xDEAD_BEEF, `stallM` releases. Without the macro -> `stallM` stays high after 100 cycles.
- Back-to-back load then store held on the M port -> the second `bus_req` rises exactly 3 cycles after the first, and no duplicate transaction is issued in DONE.
